// File: rtl/branch_predictor.sv
// branch_predictor: fetch predictor with a 2-bit counter PHT and a direct-mapped BTB.
// Define BP_GSHARE_EN to XOR a global history register into the PHT index (gshare).
module branch_predictor #(
  parameter int WIDTH        = 32,
  parameter int PHT_IDX_BITS = 6,
  parameter int BTB_IDX_BITS = 4,
  parameter int GHR_BITS     = 6
)(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [WIDTH-1:0]        pc_f_i,
  output logic                    pc_src_pred_f_o,
  output logic [WIDTH-1:0]        pred_target_f_o,
  output logic [PHT_IDX_BITS-1:0] pht_idx_f_o,
  input  logic [WIDTH-1:0]        pc_e_i,
  input  logic [PHT_IDX_BITS-1:0] pht_idx_e_i,
  input  logic [1:0]              branch_op_e_i,
  input  logic                    pc_src_res_e_i,
  input  logic [WIDTH-1:0]        pc_target_e_i,
  input  logic                    stall_e_i,
  output logic [GHR_BITS-1:0]     ghr_o
);
  localparam int PHT_N = 1 << PHT_IDX_BITS;
  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int TAG_W = WIDTH - BTB_IDX_BITS - 2;
  logic [1:0]       pht_q [PHT_N];
  logic [1:0]       pht_d [PHT_N];
  logic             btb_v_q [BTB_N];
  logic             btb_v_d [BTB_N];
  logic [TAG_W-1:0] btb_tag_q [BTB_N];
  logic [TAG_W-1:0] btb_tag_d [BTB_N];
  logic [WIDTH-1:0] btb_tgt_q [BTB_N];
  logic [WIDTH-1:0] btb_tgt_d [BTB_N];
  logic [BTB_IDX_BITS-1:0] bi_f, bi_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic [1:0] ctr_e;
  logic upd, taken, hit, unused;
  assign upd    = branch_op_e_i[0] & ~stall_e_i;
  assign taken  = pc_src_res_e_i | branch_op_e_i[1];
  assign bi_f   = pc_f_i[BTB_IDX_BITS+1:2];
  assign bi_e   = pc_e_i[BTB_IDX_BITS+1:2];
  assign tag_f  = pc_f_i[WIDTH-1:BTB_IDX_BITS+2];
  assign tag_e  = pc_e_i[WIDTH-1:BTB_IDX_BITS+2];
  assign ctr_e  = pht_q[pht_idx_e_i];
  assign unused = ^{pc_f_i[1:0], pc_e_i[1:0]};
  assign hit             = btb_v_q[bi_f] && (btb_tag_q[bi_f] == tag_f);
  assign pc_src_pred_f_o = hit & pht_q[pht_idx_f_o][1];
  assign pred_target_f_o = hit ? btb_tgt_q[bi_f] : '0;
`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  // Only conditional branches carry direction information worth recording.
  assign ghr_d       = (upd && branch_op_e_i == 2'b01) ? {ghr_q[GHR_BITS-2:0], pc_src_res_e_i} : ghr_q;
  assign ghr_o       = ghr_q;
  assign pht_idx_f_o = pc_f_i[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr_q);
  always_ff @(posedge clk_i)
    ghr_q <= reset_i ? '0 : ghr_d;
`else
  assign ghr_o       = '0;
  assign pht_idx_f_o = pc_f_i[PHT_IDX_BITS+1:2];
`endif
  always_comb begin
    pht_d     = pht_q;
    btb_v_d   = btb_v_q;
    btb_tag_d = btb_tag_q;
    btb_tgt_d = btb_tgt_q;
    if (upd)
      pht_d[pht_idx_e_i] = taken ? ((ctr_e == 2'b11) ? 2'b11 : ctr_e + 2'b01)
                                 : ((ctr_e == 2'b00) ? 2'b00 : ctr_e - 2'b01);
    if (upd && pc_src_res_e_i) begin
      btb_v_d[bi_e]   = 1'b1;
      btb_tag_d[bi_e] = tag_e;
      btb_tgt_d[bi_e] = pc_target_e_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pht_q     <= '{default: 2'b01};
      btb_v_q   <= '{default: 1'b0};
      btb_tag_q <= '{default: '0};
      btb_tgt_q <= '{default: '0};
    end else begin
      pht_q     <= pht_d;
      btb_v_q   <= btb_v_d;
      btb_tag_q <= btb_tag_d;
      btb_tgt_q <= btb_tgt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random checks of branch_predictor against a table-level model.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] pc_f, pc_e, tgt, p_tgt;
  logic [1:0] op;
  logic res, stall, pred;
  logic [5:0] pidx_e, pidx_f, ghr;
  int tests = 0, fails = 0;
  int mpht [64];
  bit mv [16];
  logic [31:0] mtag [16];
  logic [31:0] mtgt [16];
  int mghr = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk_i(clk), .reset_i(reset), .pc_f_i(pc_f), .pc_src_pred_f_o(pred),
    .pred_target_f_o(p_tgt), .pht_idx_f_o(pidx_f), .pc_e_i(pc_e), .pht_idx_e_i(pidx_e),
    .branch_op_e_i(op), .pc_src_res_e_i(res), .pc_target_e_i(tgt), .stall_e_i(stall),
    .ghr_o(ghr)
  );

  function automatic int f_pidx(logic [31:0] pc);
    int i = int'((pc >> 2) & 32'd63);
`ifdef BP_GSHARE_EN
    i = i ^ mghr;
`endif
    return i;
  endfunction

  function automatic bit f_hit(logic [31:0] pc);
    int b = int'((pc >> 2) & 32'd15);
    return mv[b] && (mtag[b] == (pc >> 6));
  endfunction

  function automatic logic [31:0] f_tgt(logic [31:0] pc);
    return f_hit(pc) ? mtgt[int'((pc >> 2) & 32'd15)] : 32'd0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mpht[i]) mpht[i] = 1;
    foreach (mv[i]) begin mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; end
    mghr = 0;
  endtask

  task automatic model_update();
    int c, b;
    if (reset) model_reset();
    else if (op[0] && !stall) begin
      c = mpht[pidx_e];
      mpht[pidx_e] = (res || op == 2'b11) ? ((c + 1 > 3) ? 3 : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
      if (res) begin
        b = int'((pc_e >> 2) & 32'd15);
        mv[b] = 1; mtag[b] = pc_e >> 6; mtgt[b] = tgt;
      end
`ifdef BP_GSHARE_EN
      if (op == 2'b01) mghr = ((mghr << 1) | int'(res)) & 63;
`endif
    end
  endtask

  task automatic go(string tag, logic [31:0] pcf, logic [31:0] pce, logic [1:0] o,
                    logic r, logic [31:0] t, logic s, logic rs);
    pc_f = pcf; pc_e = pce; op = o; res = r; tgt = t; stall = s; reset = rs;
    pidx_e = 6'(f_pidx(pce));
    #1;
    chk({tag, "_pred"}, {31'd0, pred}, {31'd0, f_hit(pc_f) && mpht[f_pidx(pc_f)] >= 2});
    chk({tag, "_tgt"}, p_tgt, f_tgt(pc_f));
    chk({tag, "_pidx"}, {26'd0, pidx_f}, 32'(f_pidx(pc_f)));
    chk({tag, "_ghr"}, {26'd0, ghr}, 32'(mghr));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pc_f = 0; pc_e = 0; op = 0; res = 0; tgt = 0; stall = 0; pidx_e = 0;
    repeat (2) @(negedge clk);
    model_reset();
    go("rst_hold", 32'h40, 32'h40, 2'b01, 1'b1, 32'h100, 1'b0, 1'b1);
    for (int a = 0; a <= 252; a += 4) go("sweep", 32'(a), 32'd0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0);
    go("train_same", 32'h40, 32'h40, 2'b01, 1'b1, 32'h100, 1'b0, 1'b0);
`ifndef BP_GSHARE_EN
    chk("train_vis_pred", {31'd0, pred}, 32'd1);
`endif
    chk("train_vis_tgt", p_tgt, 32'h100);
    repeat (4) go("sat_t", 32'h40, 32'h40, 2'b01, 1'b1, 32'h100, 1'b0, 1'b0);
    go("sat_nt1", 32'h40, 32'h40, 2'b01, 1'b0, 32'd0, 1'b0, 1'b0);
`ifndef BP_GSHARE_EN
    chk("sat_nt1_c", {31'd0, pred}, 32'd1);
`endif
    go("sat_nt2", 32'h40, 32'h40, 2'b01, 1'b0, 32'd0, 1'b0, 1'b0);
`ifndef BP_GSHARE_EN
    chk("sat_nt2_c", {31'd0, pred}, 32'd0);
`endif
    go("alias_a", 32'h40, 32'h40, 2'b01, 1'b1, 32'h100, 1'b0, 1'b0);
    go("alias_b", 32'h440, 32'h440, 2'b01, 1'b1, 32'h200, 1'b0, 1'b0);
    chk("alias_440_tgt", p_tgt, 32'h200);
    go("alias_40", 32'h40, 32'd0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("alias_40_pred", {31'd0, pred}, 32'd0);
    chk("alias_40_tgt", p_tgt, 32'd0);
    go("stall", 32'h80, 32'h80, 2'b11, 1'b1, 32'h300, 1'b1, 1'b0);
    chk("stall_tgt", p_tgt, 32'd0);
    go("stall_chk", 32'h80, 32'd0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0);
    go("rst_mid", 32'h440, 32'h440, 2'b01, 1'b1, 32'h200, 1'b0, 1'b1);
    chk("rst_mid_pred", {31'd0, pred}, 32'd0);
    chk("rst_mid_tgt", p_tgt, 32'd0);
    chk("rst_mid_ghr", {26'd0, ghr}, 32'd0);
`ifdef BP_GSHARE_EN
    go("g1", 32'h40, 32'h40, 2'b01, 1'b1, 32'h100, 1'b0, 1'b0);
    go("g2", 32'h40, 32'h40, 2'b01, 1'b0, 32'd0, 1'b0, 1'b0);
    go("g3", 32'h40, 32'h40, 2'b11, 1'b1, 32'h100, 1'b0, 1'b0);
    chk("gshare_ghr", {26'd0, ghr}, 32'h02);
    chk("gshare_pidx", {26'd0, pidx_f}, 32'h12);
`endif
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pf, pe;
      pf = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 63) << 2);
      pe = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 63) << 2);
      go("rnd", pf, pe, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
